// File: rtl/wb_sram_responder.sv
// Wishbone B4 responder in front of an internal synchronous SRAM, with wait states and registered-feedback bursts.
// Burst handling (CTI/BTE) is compiled in only when WB_SRAM_RESPONDER_BURST_EN is defined.
module wb_sram_responder #(
    parameter int unsigned              WB_ADDR_WIDTH = 32,
    parameter int unsigned              WB_DATA_WIDTH = 32,
    parameter int unsigned              MEM_WORDS     = 1024,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned              WAIT_STATES   = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    output logic                       ACK,
    output logic                       ERR
);

`ifdef WB_SRAM_RESPONDER_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam int unsigned BYTES    = WB_DATA_WIDTH / 8;
    localparam int unsigned LSB      = $clog2(BYTES);
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam int unsigned WIN_BITS = IDX_W + LSB;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;

    logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d, err_q, err_d;
    logic [WB_DATA_WIDTH-1:0] dat_r_q, rd_word;
    logic [3:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]         addr_q, addr_d, rd_idx, nxt_idx, adr_idx, wrap_mask;
    logic [IDX_W:0]           inc;
    logic                     hit_q, hit_d, we_q, we_d, nxt_oob, adr_hit;
    logic [1:0]               bte_q, bte_d;
    logic                     stb_act, beat_done, ld_dat, wr_en;
    logic                     unused_adr;

    assign unused_adr = ^ADR[LSB-1:0];

    assign stb_act   = CYC & STB;
    assign beat_done = stb_act & (ack_q | err_q);
    assign adr_idx   = ADR[WIN_BITS-1:LSB];
    assign adr_hit   = (ADR[WB_ADDR_WIDTH-1:WIN_BITS] == BASE_ADDR[WB_ADDR_WIDTH-1:WIN_BITS]);

    assign ACK   = ack_q & stb_act;
    assign ERR   = err_q & stb_act;
    assign DAT_R = dat_r_q;

    // Wrap bursts keep the upper index bits and roll only the low log2(N) bits
    always_comb begin
        inc       = {1'b0, addr_q} + {{IDX_W{1'b0}}, 1'b1};
        wrap_mask = '0;
        case (bte_q)
            2'b01:   wrap_mask = IDX_W'(3);
            2'b10:   wrap_mask = IDX_W'(7);
            2'b11:   wrap_mask = IDX_W'(15);
            default: wrap_mask = '0;
        endcase
        if (bte_q == 2'b00) begin
            nxt_idx = inc[IDX_W-1:0];
            nxt_oob = inc[IDX_W];
        end else begin
            nxt_idx = (addr_q & ~wrap_mask) | (inc[IDX_W-1:0] & wrap_mask);
            nxt_oob = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hit_d   = hit_q;
        we_d    = we_q;
        bte_d   = bte_q;
        ld_dat  = 1'b0;
        rd_idx  = addr_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                err_d = 1'b0;
                if (stb_act) begin
                    addr_d = adr_idx;
                    hit_d  = adr_hit;
                    we_d   = WE;
                    bte_d  = BTE;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        ack_d   = adr_hit;
                        err_d   = ~adr_hit;
                        ld_dat  = 1'b1;
                        rd_idx  = adr_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!stb_act) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    ack_d   = hit_q;
                    err_d   = ~hit_q;
                    ld_dat  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP, BURST: begin
                if (!CYC) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end else if (beat_done) begin
                    wr_en = we_q & ack_q;
                    if (BURST_EN && ack_q && CTI == 3'b010) begin
                        state_d = BURST;
                        addr_d  = nxt_idx;
                        ld_dat  = 1'b1;
                        rd_idx  = nxt_idx;
                        ack_d   = ~nxt_oob;
                        err_d   = nxt_oob;
                    end else begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Forward the beat being written so a same-word read never returns stale data
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_en && rd_idx == addr_q) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (SEL[i]) rd_word[i*8 +: 8] = DAT_W[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (SEL[i]) mem[addr_q][i*8 +: 8] <= DAT_W[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            hit_q   <= 1'b0;
            we_q    <= 1'b0;
            bte_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            we_q    <= we_d;
            bte_q   <= bte_d;
            if (ld_dat) dat_r_q <= err_d ? '0 : rd_word;
        end
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: two instances (0 and 3 wait states) against a word-array reference model.
// Burst scenarios are exercised when WB_SRAM_RESPONDER_BURST_EN is defined; otherwise CTI=010 must behave as classic.
module tb_wb_sram_responder;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] adr = '0, dat_w = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0;
    logic [31:0] dat_r0, dat_r1;
    logic        ack0, err0, ack1, err1;

    logic [31:0] model [2][MEM_WORDS];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    wb_sram_responder #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS),
                        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .ADR(adr), .CTI(cti), .BTE(bte), .DAT_W(dat_w), .DAT_R(dat_r0),
        .CYC(cyc0), .STB(stb0), .WE(we), .SEL(sel), .ACK(ack0), .ERR(err0));

    wb_sram_responder #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS),
                        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rstn(rstn), .ADR(adr), .CTI(cti), .BTE(bte), .DAT_W(dat_w), .DAT_R(dat_r1),
        .CYC(cyc1), .STB(stb1), .WE(we), .SEL(sel), .ACK(ack1), .ERR(err1));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [1:0] resp(input int d);
        return (d == 0) ? {ack0, err0} : {ack1, err1};
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? dat_r0 : dat_r1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic set_cs(input int d, input logic v);
        if (d == 0) begin cyc0 = v; stb0 = v; end
        else        begin cyc1 = v; stb1 = v; end
    endtask

    // One classic beat; expected latency is WAIT_STATES+1 and the response must last a single cycle
    task automatic wb_classic(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input logic [2:0] c, input string tag,
                              output logic [31:0] rd);
        int unsigned idx;
        logic        hit;
        int          lat;
        idx = a >> 2;
        hit = (a < MEM_WORDS * 4);
        lat = 0;
        @(negedge clk);
        adr = a; we = w; dat_w = wd; sel = s; cti = c; bte = 2'($urandom);
        set_cs(d, 1'b1);
        while (resp(d) == 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_lat"}, lat, (d == 0) ? 1 : 4);
        check_val({tag, "_resp"}, {30'd0, resp(d)}, hit ? 32'd2 : 32'd1);
        rd = rdat(d);
        if (!hit) check_val({tag, "_errdat"}, rd, 32'd0);
        else if (!w) check_val({tag, "_rdat"}, rd, model[d][idx]);
        else model[d][idx] = merge(model[d][idx], wd, s);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_end"}, {30'd0, resp(d)}, 32'd0);
        set_cs(d, 1'b0);
    endtask

    // Burst on instance 0; expected beat addresses come from plain modular arithmetic
    task automatic wb_burst(input logic w, input logic [31:0] a, input logic [1:0] b, input int n,
                            input int gap_at, input int rst_at, input string tag);
        int unsigned idx0, blen, e;
        logic        eerr;
        int          k;
        idx0 = a >> 2;
        blen = 2 << b;
        @(negedge clk);
        adr = a; we = w; bte = b; cti = (n == 1) ? 3'b111 : 3'b010;
        dat_w = $urandom; sel = 4'($urandom);
        cyc0 = 1'b1; stb0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (b == 2'b00) e = idx0 + i;
            else            e = idx0 - (idx0 % blen) + ((idx0 % blen) + i) % blen;
            eerr = (e >= MEM_WORDS);
            k = 0;
            while (resp(0) == 2'b00 && k < 20) begin
                @(negedge clk);
                k++;
            end
            check_val($sformatf("%s_b%0d_resp", tag, i), {30'd0, resp(0)}, eerr ? 32'd1 : 32'd2);
            if (eerr) check_val($sformatf("%s_b%0d_errdat", tag, i), dat_r0, 32'd0);
            else if (!w) check_val($sformatf("%s_b%0d_rdat", tag, i), dat_r0, model[0][e]);
            else model[0][e] = merge(model[0][e], dat_w, sel);
            if (i == rst_at) begin
                @(posedge clk);
                #1 rstn = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_val({tag, "_rst"}, {30'd0, resp(0)}, 32'd0);
                rstn = 1'b1; cyc0 = 1'b0; stb0 = 1'b0;
                return;
            end
            if (eerr || i == n - 1) break;
            @(posedge clk);
            #1;
            cti = (i + 1 == n - 1) ? 3'b111 : 3'b010;
            dat_w = $urandom; sel = 4'($urandom);
            if (i == gap_at) begin
                stb0 = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check_val({tag, "_gap"}, {30'd0, resp(0)}, 32'd0);
                end
                stb0 = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_end"}, {30'd0, resp(0)}, 32'd0);
        cyc0 = 1'b0; stb0 = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          d, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_resp0", {30'd0, resp(0)}, 32'd0);
        check_val("rst_dat0", dat_r0, 32'd0);
        check_val("rst_dat1", dat_r1, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) wb_classic(0, 1'b1, i * 4, i, 4'hF, 3'b000, "fill0", rd);
        for (int i = 0; i < 64; i++) wb_classic(1, 1'b1, i * 4, i, 4'hF, 3'b000, "fill1", rd);

        wb_classic(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, "wr_dead", rd);
        wb_classic(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, "rd_dead", rd);
        check_val("deadbeef", rd, 32'hDEADBEEF);
        wb_classic(1, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, "ws3_rd", rd);
        wb_classic(0, 1'b1, 32'h14, 32'h11223344, 4'hF, 3'b000, "sel_base", rd);
        wb_classic(0, 1'b1, 32'h14, 32'h0000AB00, 4'b0010, 3'b000, "sel_wr", rd);
        wb_classic(0, 1'b0, 32'h14, 32'h0, 4'hF, 3'b000, "sel_rd", rd);
        check_val("sel_merge", rd, 32'h1122AB44);
        wb_classic(0, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b000, "oob_rd", rd);
        wb_classic(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 3'b000, "oob_wr", rd);
        wb_classic(1, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b000, "oob_rd1", rd);
        wb_classic(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, "oob_wr_nochg", rd);

`ifdef WB_SRAM_RESPONDER_BURST_EN
        wb_burst(1'b0, 32'h8, 2'b01, 4, -1, -1, "wrap4");
        wb_burst(1'b0, 32'hFFC, 2'b00, 3, -1, -1, "lin_end");
        wb_classic(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, "after_end", rd);
        wb_burst(1'b0, 32'h40, 2'b00, 4, 1, -1, "gap");
        wb_burst(1'b0, 32'h80, 2'b00, 6, -1, 1, "rst_mid");
        wb_burst(1'b0, 32'h1000, 2'b00, 3, -1, -1, "oob_burst");
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(1, 8);
            wb_burst(1'($urandom), $urandom_range(0, MEM_WORDS - 1) * 4, 2'($urandom), n,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1, -1, "rnd_burst");
        end
`else
        wb_classic(0, 1'b0, 32'h8, 32'h0, 4'hF, 3'b010, "nb_cti0", rd);
        wb_classic(0, 1'b0, 32'hC, 32'h0, 4'hF, 3'b010, "nb_cti1", rd);
        wb_classic(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 3'b010, "nb_cti2", rd);
        wb_classic(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 3'b010, "nb_cti3", rd);
`endif

        for (int i = 0; i < 80; i++) begin
            d = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
            else a = (($urandom_range(0, (d == 0) ? MEM_WORDS - 1 : 63)) * 4) | $urandom_range(0, 3);
            wb_classic(d, 1'($urandom), a, $urandom, 4'($urandom), 3'b000, "rnd", rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
